// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Rev 1.0
`default_nettype none

module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            last_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o
);

  localparam int                IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int                BEAT_W   = $clog2(MAX_BURST) + 1;
  localparam logic [IDX_W-1:0]  OWN_RST  = IDX_W'(NUM_REQ - 1);
  localparam logic [BEAT_W-1:0] BEAT_END = BEAT_W'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [IDX_W-1:0]      sel;
  logic                  sel_vld;
  logic                  busy;
  logic                  accept;
  logic                  burst_end;

  generate
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign data_arr[k] = data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Scan downward so the nearest requester after the previous owner wins;
  // owner_q doubles as last_owner since it persists through IDLE.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req_i[(int'(owner_q) + i) % NUM_REQ]) begin
        sel     = IDX_W'((int'(owner_q) + i) % NUM_REQ);
        sel_vld = 1'b1;
      end
    end
  end

  assign busy      = (state_q == BURST);
  assign accept    = busy & req_i[owner_q] & ~fifo_full_i;
  assign burst_end = accept & (last_i[owner_q] | (beat_q == BEAT_END));

  assign busy_o       = busy;
  assign grant_o      = grant_q;
  assign fifo_wr_en_o = accept;
  assign ack_o        = accept ? grant_q : '0;
  assign fifo_data_o  = busy ? data_arr[owner_q] : '0;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d      = BURST;
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          owner_d      = sel;
          beat_d       = '0;
        end
      end
      BURST: begin
        if (!req_i[owner_q] || burst_end) begin
          state_d = IDLE;
          grant_d = '0;
          beat_d  = '0;
        end else if (accept) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= OWN_RST;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
    end
  end

endmodule

`default_nettype wire
